aes_shift_rows_unit: RTL and testbench
======================================

// Module: aes_shift_rows_unit
// PURPOSE
//   AES ShiftRows / InvShiftRows byte permutation on one 128-bit state, mode-selectable per beat.
//   Sits in the AES round datapath between SubBytes and MixColumns (encrypt), or between
//   InvShiftRows-consumer stages (decrypt).
//   Output registered by default, 1-cycle latency, one beat per cycle, no back-pressure.
//   Also exposes both raw combinational permutations for reuse by the round controller.
// PARAMETERS
//   REGISTER_OUTPUT  1  1 = registered output (latency 1); 0 = out_* driven combinationally from in_* (latency 0)
// PORTS
//   clk        in   1    single clock; all state updates on rising edge
//   rst_n      in   1    synchronous, active-low reset (sampled on rising clk edge)
//   in_valid   in   1    in_state/inv carry a beat this cycle
//   inv        in   1    0 = ShiftRows (forward), 1 = InvShiftRows; sampled with in_valid
//   in_state   in   128  AES state, FIPS-197 byte order: byte k = in_state[127-8k -: 8], k=0..15
//   out_valid  out  1    out_state carries a result this cycle
//   out_state  out  128  permuted state, same byte order
//   fwd_comb   out  128  combinational ShiftRows(in_state), independent of inv/in_valid/clock
//   inv_comb   out  128  combinational InvShiftRows(in_state), independent of inv/in_valid/clock
// BEHAVIOUR
//   - State matrix s[r][c] = byte (4c+r), r=row 0..3, c=column 0..3 (column-major, byte 0 = MSB).
//   - Forward: out[r][c] = in[r][(c+r) mod 4]   (row r rotated left by r bytes).
//   - Inverse: out[r][c] = in[r][(c-r) mod 4]   (row r rotated right by r bytes).
//   - Row 0 never moves; pure byte wiring, no arithmetic; bytes never split or altered.
//   - Inverse(Forward(x)) = Forward(Inverse(x)) = x for every x.
//   - REGISTER_OUTPUT=1:
//     * On rising clk with rst_n=0: out_valid<=0, out_state<=128'h0. Reset wins over in_valid.
//     * Else out_valid <= in_valid.
//     * If in_valid=1: out_state <= (inv ? inv_comb : fwd_comb), using inv of that same cycle.
//     * If in_valid=0: out_state holds its previous value (no update, no clearing).
//     * Back-to-back beats every cycle, mode may change beat-to-beat; each beat uses its own inv.
//     * Reset mid-stream: beat in flight discarded; first cycle after rst_n rises shows out_valid=0.
//   - REGISTER_OUTPUT=0: out_valid = in_valid, out_state = inv ? inv_comb : fwd_comb,
//     purely combinational; clk/rst_n unused.
//   - fwd_comb/inv_comb valid whenever in_state is stable, regardless of reset, mode, valid.
//   - No X propagation from inv when in_valid=0 (register not enabled).
// TESTING
//   - Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, out_state=0 throughout.
//   - Forward FIPS-197: in_state=d42711aee0bf98f1b8b45de51e415230, inv=0, in_valid=1
//     -> next cycle out_valid=1, out_state=d4bf5d30e0b452aeb84111f11e2798e5.
//   - Inverse: in_state=d4bf5d30e0b452aeb84111f11e2798e5, inv=1 -> out_state=d42711aee0bf98f1b8b45de51e415230.
//   - Index pattern: in_state=000102030405060708090a0b0c0d0e0f -> fwd_comb=00050a0f04090e03080d02070c01060b,
//     inv_comb=000d0a0704010e0b0805020f0c090603 (same cycle, combinational).
//   - Back-to-back alternating inv=0,1,0 on 3 beats + 20 random vectors -> each output matches
//     per-beat golden one cycle later; random x: inv(fwd(x))==x; idle cycle holds out_state, out_valid=0.
//   - Reset mid-stream: assert rst_n=0 while beat in flight -> out_valid=0, out_state=0 next edge.

Source files
------------

// File: rtl/aes_shift_rows_unit.sv
// aes_shift_rows_unit
//   AES ShiftRows / InvShiftRows byte permutation on one 128-bit state.
//   The direction is selectable per beat. The output is registered when
//   REGISTER_OUTPUT=1 (latency 1) and combinational when REGISTER_OUTPUT=0
//   (latency 0). Both raw permutations are also exported combinationally.
//
// Parameters
//   REGISTER_OUTPUT : 1 = registered out_* (latency 1); 0 = combinational out_*
//
// Ports
//   clk        in   1    clock, rising-edge
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    beat present on in_state/inv
//   inv        in   1    0 = ShiftRows, 1 = InvShiftRows (sampled with in_valid)
//   in_state   in   128  state, byte k = in_state[127-8k -: 8]
//   out_valid  out  1    out_state carries a result
//   out_state  out  128  permuted state, same byte order
//   fwd_comb   out  128  ShiftRows(in_state), combinational
//   inv_comb   out  128  InvShiftRows(in_state), combinational
module aes_shift_rows_unit #(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  output logic [127:0] out_state,
  output logic [127:0] fwd_comb,
  output logic [127:0] inv_comb
);

  logic [127:0] w_fwd;
  logic [127:0] w_inv;
  logic [127:0] w_sel;

  // Byte (4c+r) is matrix cell s[r][c]. Forward takes s[r][(c+r)%4],
  // inverse takes s[r][(c-r)%4]; pure wiring, row 0 is a pass-through.
  always_comb begin
    w_fwd = '0;
    w_inv = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        w_fwd[127 - 8*(4*c + r) -: 8] = in_state[127 - 8*(4*((c + r) % 4) + r) -: 8];
        w_inv[127 - 8*(4*c + r) -: 8] = in_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
  end

  assign fwd_comb = w_fwd;
  assign inv_comb = w_inv;
  assign w_sel    = inv ? w_inv : w_fwd;

  generate
    if (REGISTER_OUTPUT) begin : g_reg
      logic         r_valid;
      logic [127:0] r_state;

      // State only loads on a valid beat, so inv is ignored while idle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_state <= '0;
        end else begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_state <= w_sel;
          end
        end
      end

      assign out_valid = r_valid;
      assign out_state = r_state;
    end else begin : g_comb
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;

      assign out_valid = in_valid;
      assign out_state = w_sel;
    end
  endgenerate

endmodule

// File: tb/tb_aes_shift_rows_unit.sv
// Directed bench for aes_shift_rows_unit (REGISTER_OUTPUT=1).
module tb_aes_shift_rows_unit;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inv;
  logic [127:0] in_state;
  logic         out_valid;
  logic [127:0] out_state;
  logic [127:0] fwd_comb;
  logic [127:0] inv_comb;

  int unsigned n_checks;
  int unsigned n_errors;

  aes_shift_rows_unit #(.REGISTER_OUTPUT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inv       (inv),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_state (out_state),
    .fwd_comb  (fwd_comb),
    .inv_comb  (inv_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %032h expected %032h", tag, got, exp);
    end
  endtask

  // Reference: gather each row into a 32-bit word, rotate it, scatter back.
  function automatic logic [127:0] ref_shift(input logic [127:0] x, input bit inverse);
    logic [127:0] y;
    logic [31:0]  row;
    logic [63:0]  dbl;
    logic [31:0]  rot;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[31 - 8*c -: 8] = x[127 - 8*(4*c + r) -: 8];
      dbl = {row, row};
      if (inverse) rot = dbl[63 - 32 + 8*r -: 32];
      else         rot = dbl[63 - 8*r -: 32];
      for (int c = 0; c < 4; c++) y[127 - 8*(4*c + r) -: 8] = rot[31 - 8*c -: 8];
    end
    return y;
  endfunction

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] IDX_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IDX_FWD  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] IDX_INV  = 128'h000d0a0704010e0b0805020f0c090603;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] held;
  logic [127:0] x;
  logic [127:0] exp_v;
  logic [127:0] rnd;
  bit           m;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inv      = 1'b0;
    in_state = FIPS_IN;

    // Reset wins over in_valid
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_valid", {127'd0, out_valid}, 128'd0);
      check("rst_state", out_state, 128'd0);
    end

    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    check("post_rst_valid", {127'd0, out_valid}, 128'd0);

    // FIPS-197 forward and inverse
    in_valid = 1'b1;
    inv      = 1'b0;
    in_state = FIPS_IN;
    #1;
    check("fips_fwd_comb", fwd_comb, FIPS_OUT);
    step();
    check("fips_fwd_valid", {127'd0, out_valid}, 128'd1);
    check("fips_fwd_state", out_state, FIPS_OUT);

    inv      = 1'b1;
    in_state = FIPS_OUT;
    #1;
    check("fips_inv_comb", inv_comb, FIPS_IN);
    step();
    check("fips_inv_valid", {127'd0, out_valid}, 128'd1);
    check("fips_inv_state", out_state, FIPS_IN);

    // Index pattern, combinational outputs only
    in_valid = 1'b0;
    in_state = IDX_IN;
    #1;
    check("idx_fwd_comb", fwd_comb, IDX_FWD);
    check("idx_inv_comb", inv_comb, IDX_INV);

    // Idle: out_state held, mode toggling has no effect
    held = out_state;
    inv  = 1'b0;
    step();
    check("idle_valid", {127'd0, out_valid}, 128'd0);
    check("idle_hold", out_state, held);
    inv = 1'b1;
    step();
    check("idle_hold2", out_state, held);

    // Back-to-back alternating modes
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m        = (i == 1);
      inv      = m;
      in_state = IDX_IN;
      step();
      check("b2b_valid", {127'd0, out_valid}, 128'd1);
      check("b2b_state", out_state, m ? IDX_INV : IDX_FWD);
    end

    // Random back-to-back beats with per-beat mode
    for (int i = 0; i < 20; i++) begin
      rnd      = {$urandom, $urandom, $urandom, $urandom};
      m        = bit'($urandom_range(0, 1));
      inv      = m;
      in_state = rnd;
      exp_v    = ref_shift(rnd, m);
      step();
      check("rnd_valid", {127'd0, out_valid}, 128'd1);
      check("rnd_state", out_state, exp_v);
    end

    // Round trips through the combinational outputs
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x        = {$urandom, $urandom, $urandom, $urandom};
      in_state = x;
      #1;
      in_state = fwd_comb;
      #1;
      check("rt_inv_fwd", inv_comb, x);
      in_state = x;
      #1;
      in_state = inv_comb;
      #1;
      check("rt_fwd_inv", fwd_comb, x);
    end

    // Reset with a beat in flight
    in_valid = 1'b1;
    inv      = 1'b0;
    in_state = FIPS_IN;
    step();
    check("mid_pre_valid", {127'd0, out_valid}, 128'd1);
    check("mid_pre_state", out_state, FIPS_OUT);
    rst_n    = 1'b0;
    inv      = 1'b1;
    in_state = FIPS_OUT;
    step();
    check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_state", out_state, 128'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    check("mid_post_valid", {127'd0, out_valid}, 128'd0);
    check("mid_post_state", out_state, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
